gpio_reg_bank: RTL
==================

// Module: gpio_reg_bank
// PURPOSE
//  Parametrised GPIO-addressed configuration register bank for the lock-in tops (e.g. NCO increment, gain scalar, control bits).
//  Captures PS GPIO byte writes into per-register shadow words and commits them to live outputs atomically (global or per-register).
//  Also drives gpio_out with readback of any live register or a status word.
//  Sits between the PS GPIO and the lock-in datapath. Replaces per-address single-register instances plus the output mux.
// PARAMETERS
//  N_REGS       8        number of 32-bit registers (1..64)
//  LANE_W       2        byte-lane address bits; BYTES = 2**LANE_W bytes per register (fixed 32-bit regs => LANE_W=2)
//  COMMIT_ADDR  16'hFFFF bus address whose write commits all shadows to live
//  RDSEL_ADDR   16'hFFFE bus address whose write data selects the readback index
//  AUTO_COMMIT  0        1: writing lane BYTES-1 of a register also commits that register alone
//  RESET_VALS   0        N_REGS*32-bit flat vector of reset values, reg i at [32*i+:32]
// PORTS
//  clk          in   1            system clock (ADC clock domain)
//  rst          in   1            synchronous, active-low reset
//  gpio_in      in   32           [15:0] addr, [23:16] data byte, [24] w_clk write strobe, [31:25] ignored
//  regs_o       out  N_REGS*32    live register values, reg i at [32*i+:32]
//  commit_o     out  1            one-cycle pulse on any commit
//  gpio_out     out  32           readback word
// BEHAVIOUR
//  - Reset (rst==0 at posedge clk): shadow and live = RESET_VALS; rd_sel=0; commit_cnt=0; err_cnt=0; commit_o=0.
//  - Reset: w_clk sync flops = 1, so a strobe held high across reset release produces no write.
//  - Strobe: gpio_in[24] passes a 2-FF synchroniser. A write event is sync 0->1 (edge on 2nd stage).
//  - Strobe: addr/data are sampled in the event cycle; PS holds them stable while w_clk is high.
//  - Strobe: one event per rising edge regardless of high time.
//  - Decode, with addr = gpio_in[15:0], idx = addr[15:LANE_W], lane = addr[LANE_W-1:0]:
//    - addr==COMMIT_ADDR: live <= shadow for all regs.
//    - addr==RDSEL_ADDR: rd_sel <= data.
//    - idx<N_REGS: shadow[idx][8*lane+:8] <= data.
//    - otherwise: no write; err_cnt increments, saturating at 16'hFFFF.
//  - COMMIT_ADDR/RDSEL_ADDR take precedence over the index decode.
//  - AUTO_COMMIT=1, lane==BYTES-1: live[idx] <= shadow word including the new byte, in the same cycle as the shadow write.
//  - Latency: w_clk rising at pin -> shadow written at 3rd posedge. Commit -> regs_o updated at the same edge as the commit.
//  - Latency: commit_o is high for exactly the cycle after that edge (registered).
//  - commit_cnt increments (wrapping, 16 bit) on every commit event, global or auto.
//  - Readback (registered, 1-cycle):
//    - rd_sel<N_REGS: gpio_out = live[rd_sel].
//    - rd_sel==8'hFF: gpio_out = {commit_cnt, err_cnt}.
//    - rd_sel==8'hFE: gpio_out = shadow[0] (debug).
//    - else gpio_out = 32'h0.
//  - Bus order rule: live values never show partial byte updates; only commit events change regs_o.
//  - Reset asserted mid-sequence discards uncommitted shadow bytes (all return to RESET_VALS).
//  - No state machine beyond sync/edge/decode; single write per event, no simultaneous-event case exists on the bus.
// STRUCTURE
//  - Package lockin_cfg_pkg: GPIO field positions (ADDR_MSB=15, DATA_LSB=16, DATA_MSB=23, WCLK_BIT=24).
//  - Package lockin_cfg_pkg: COMMIT_ADDR/RDSEL_ADDR defaults.
//  - Package lockin_cfg_pkg: readback codes RB_STATUS=8'hFF, RB_SHADOW0=8'hFE.
//  - Package lockin_cfg_pkg: per-design register index constants (CNTR=0, SINC=1, INC=2, SCALAR=3).
//  - Sub-module gpio_wstrobe_sync: 2-FF sync + rising-edge detect + addr/data capture.
//    - Outputs: wr_evt, wr_addr[15:0], wr_data[7:0].
//  - Remainder of the bank: decode, shadow/live arrays, counters and readback mux.
// TESTING
//  1. RESET_VALS with reg2=32'h0000_1000; hold rst=0 for 4 clk -> regs_o reg2=32'h0000_1000, gpio_out=0, commit_o=0.
//  2. Write 16'h0008..000B bytes 78,56,34,12, then no commit -> reg2 live unchanged.
//     Write COMMIT_ADDR -> reg2=32'h1234_5678 and commit_o pulses exactly 1 cycle.
//  3. AUTO_COMMIT=1: write lanes 0,1,2 of reg1 -> no change. Write lane 3 -> reg1 updates alone; other regs keep prior live.
//  4. Write addr 16'h0040 with N_REGS=8 -> no reg changes; rd_sel=FF readback = {commit_cnt, 16'h0001}.
//     Repeat 65536+ times -> err field saturates at 16'hFFFF.
//  5. Hold w_clk high 20 cycles -> exactly one write.
//     Assert rst with w_clk high, release -> no write.
//     Toggle w_clk at 1/4 clk rate -> every edge captured.
//  6. RDSEL=3 after committing 32'hDEAD_BEEF to reg3 -> gpio_out=32'hDEAD_BEEF one cycle after the select.
//     RDSEL=9 (N_REGS=8) -> gpio_out=0.

Source files
------------

// File: rtl/gpio_reg_bank_pkg.sv
// Shared constants for the lock-in configuration register bank:
// GPIO field positions, special bus addresses, readback codes and
// the register map used by the lock-in tops.
package lockin_cfg_pkg;

  // GPIO input word layout
  localparam int ADDR_MSB = 15;
  localparam int DATA_LSB = 16;
  localparam int DATA_MSB = 23;
  localparam int WCLK_BIT = 24;

  // Default special addresses
  localparam logic [15:0] DEF_COMMIT_ADDR = 16'hFFFF;
  localparam logic [15:0] DEF_RDSEL_ADDR  = 16'hFFFE;

  // Readback selector codes beyond the register range
  localparam logic [7:0] RB_STATUS  = 8'hFF;
  localparam logic [7:0] RB_SHADOW0 = 8'hFE;

  // Lock-in register map
  localparam int REG_CNTR   = 0;
  localparam int REG_SINC   = 1;
  localparam int REG_INC    = 2;
  localparam int REG_SCALAR = 3;

  // Classification of one bus write event
  typedef enum logic [2:0] {
    DEC_NONE,
    DEC_COMMIT,
    DEC_RDSEL,
    DEC_REG,
    DEC_ERR
  } dec_e;

  // Replace one byte lane of a 32-bit word.
  function automatic logic [31:0] set_byte(input logic [31:0] word,
                                           input logic [1:0]  lane,
                                           input logic [7:0]  data);
    logic [31:0] res;
    res = word;
    res[8*lane +: 8] = data;
    return res;
  endfunction

endpackage

// File: rtl/gpio_reg_bank_wstrobe_sync.sv
// Brings the PS GPIO write strobe into the ADC clock domain and turns
// each rising edge into a single-cycle write event. Address and data
// are held stable by the PS while the strobe is high, so they are
// taken straight from the bus in the event cycle.
module gpio_wstrobe_sync
  import lockin_cfg_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_gpio,
  output logic        o_wr_evt,
  output logic [15:0] o_wr_addr,
  output logic [7:0]  o_wr_data
);

  logic r_sync1;
  logic r_sync2;
  logic r_sync2_d;
  logic w_unused;

  // Two-stage synchroniser plus one delay stage for edge detection.
  always_ff @(posedge clk) begin
    if (!rst) begin
      // NOTE: these reset to 1, not 0, so a strobe already high when reset
      // releases is seen as "no change" instead of a fresh rising edge.
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_sync2_d <= 1'b1;
    end else begin
      r_sync1   <= i_gpio[WCLK_BIT];
      r_sync2   <= r_sync1;
      r_sync2_d <= r_sync2;
    end
  end

  assign o_wr_evt  = r_sync2 & ~r_sync2_d;
  assign o_wr_addr = i_gpio[ADDR_MSB:0];
  assign o_wr_data = i_gpio[DATA_MSB:DATA_LSB];

  // Bits above the strobe carry no meaning on this bus.
  assign w_unused = &{1'b0, i_gpio[31:WCLK_BIT+1]};

endmodule

// File: rtl/gpio_reg_bank.sv
// GPIO-addressed configuration register bank. Byte writes land in
// per-register shadow words; live outputs change only on a commit
// (global commit address, or per-register auto commit on the top lane),
// so the datapath never sees a half-written word. A registered readback
// mux returns a live register, the status counters or shadow word 0.
module gpio_reg_bank
  import lockin_cfg_pkg::*;
#(
  parameter int                   N_REGS      = 8,
  parameter int                   LANE_W      = 2,
  parameter logic [15:0]          COMMIT_ADDR = DEF_COMMIT_ADDR,
  parameter logic [15:0]          RDSEL_ADDR  = DEF_RDSEL_ADDR,
  parameter bit                   AUTO_COMMIT = 1'b0,
  parameter logic [N_REGS*32-1:0] RESET_VALS  = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           gpio_in,
  output logic [N_REGS*32-1:0]  regs_o,
  output logic                  commit_o,
  output logic [31:0]           gpio_out
);

  localparam int BYTES  = 1 << LANE_W;
  localparam int SLOT_W = 16 - LANE_W;
  localparam int IDX_W  = (N_REGS > 1) ? $clog2(N_REGS) : 1;

  logic              w_wr_evt;
  logic [15:0]       w_wr_addr;
  logic [7:0]        w_wr_data;
  logic [SLOT_W-1:0] w_slot;
  logic [LANE_W-1:0] w_lane;
  logic [IDX_W-1:0]  w_idx;
  logic              w_idx_ok;
  logic              w_auto;
  logic [31:0]       w_new_word;
  dec_e              w_dec;

  logic [31:0]       r_shadow [N_REGS];
  logic [31:0]       r_live   [N_REGS];
  logic [7:0]        r_rd_sel;
  logic [15:0]       r_commit_cnt;
  logic [15:0]       r_err_cnt;
  logic              r_commit;
  logic [31:0]       r_gpio_out;

  gpio_wstrobe_sync u_wstrobe_sync (
    .clk       (clk),
    .rst       (rst),
    .i_gpio    (gpio_in),
    .o_wr_evt  (w_wr_evt),
    .o_wr_addr (w_wr_addr),
    .o_wr_data (w_wr_data)
  );

  assign w_slot     = w_wr_addr[15:LANE_W];
  assign w_lane     = w_wr_addr[LANE_W-1:0];
  assign w_idx      = w_slot[IDX_W-1:0];
  assign w_idx_ok   = (32'(w_slot) < 32'(N_REGS));
  assign w_auto     = AUTO_COMMIT && (w_lane == LANE_W'(BYTES - 1));
  assign w_new_word = set_byte(r_shadow[w_idx], 2'(w_lane), w_wr_data);

  // Classify the write event; special addresses win over the index decode.
  always_comb begin
    // NOTE: default first so every path assigns w_dec and no latch is inferred.
    w_dec = DEC_NONE;
    if (w_wr_evt) begin
      if (w_wr_addr == COMMIT_ADDR)      w_dec = DEC_COMMIT;
      else if (w_wr_addr == RDSEL_ADDR)  w_dec = DEC_RDSEL;
      else if (w_idx_ok)                 w_dec = DEC_REG;
      else                               w_dec = DEC_ERR;
    end
  end

  // Shadow/live arrays, readback selector, counters and the commit pulse.
  always_ff @(posedge clk) begin
    if (!rst) begin
      // NOTE: the arrays are reset on purpose: a reset must drop any
      // uncommitted shadow bytes and restore the power-up register values.
      for (int i = 0; i < N_REGS; i++) begin
        r_shadow[i] <= RESET_VALS[32*i +: 32];
        r_live[i]   <= RESET_VALS[32*i +: 32];
      end
      r_rd_sel     <= 8'h00;
      r_commit_cnt <= 16'h0000;
      r_err_cnt    <= 16'h0000;
      r_commit     <= 1'b0;
    end else begin
      r_commit <= 1'b0;
      case (w_dec)
        DEC_COMMIT: begin
          for (int i = 0; i < N_REGS; i++) r_live[i] <= r_shadow[i];
          r_commit_cnt <= r_commit_cnt + 16'd1;
          r_commit     <= 1'b1;
        end
        DEC_RDSEL: r_rd_sel <= w_wr_data;
        DEC_REG: begin
          r_shadow[w_idx] <= w_new_word;
          if (w_auto) begin
            r_live[w_idx] <= w_new_word;
            r_commit_cnt  <= r_commit_cnt + 16'd1;
            r_commit      <= 1'b1;
          end
        end
        DEC_ERR: begin
          if (r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;
        end
        default: ;
      endcase
    end
  end

  // Registered readback mux.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_gpio_out <= 32'h0;
    end else if (32'(r_rd_sel) < 32'(N_REGS)) begin
      r_gpio_out <= r_live[r_rd_sel[IDX_W-1:0]];
    end else if (r_rd_sel == RB_STATUS) begin
      r_gpio_out <= {r_commit_cnt, r_err_cnt};
    end else if (r_rd_sel == RB_SHADOW0) begin
      r_gpio_out <= r_shadow[0];
    end else begin
      r_gpio_out <= 32'h0;
    end
  end

  // Flatten the live array onto the output bus.
  always_comb begin
    regs_o = '0;
    for (int i = 0; i < N_REGS; i++) regs_o[32*i +: 32] = r_live[i];
  end

  assign commit_o = r_commit;
  assign gpio_out = r_gpio_out;

endmodule
